pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Hazard and memory-wait controller for the three-stage RISC-V pipeline (IF → EXE → MWB). It watches the instructions held in the IF2EXE and EXE2MWB registers and drives the hold, flush and bubble controls for the PC, IF2EXE and EXE2MWB registers. It handles three things: data-memory waits, load-use hazards and taken-branch redirects. It also drives the EXE operand-forwarding selects, detects data-memory timeouts and keeps a stall-cycle counter.

## Interface
Parameters:
- TIMEOUT, 16: number of MEM_WAIT cycles before a data-memory access is force-completed; legal range ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- exe_instr  in  32  instruction currently in EXE (IF2EXE output)
- mwb_instr  in  32  instruction currently in MWB (EXE2MWB instruction_out)
- mwb_reg_we  in  1  MWB register write enable
- mwb_dmem_sel  in  2  MWB memory op: 0 none, 1 load, 2 store, 3 reserved (treated as none)
- dmem_ready  in  1  data memory completes the MWB access this cycle
- branch_taken  in  1  EXE resolved a taken branch/jump this cycle
- pc_stall  out  1  hold PC
- if2exe_stall  out  1  hold IF2EXE register
- if2exe_flush  out  1  IF2EXE loads NOP (32'h00000013) at next edge
- exe2mwb_stall  out  1  hold EXE2MWB register
- exe2mwb_bubble  out  1  EXE2MWB loads all-zero (no write, no mem op) at next edge
- dmem_req  out  1  data-memory request for the MWB instruction
- fwd_rs1, fwd_rs2  out  1 each  EXE operand takes the MWB ALU result instead of the register file
- mem_err  out  1  sticky timeout flag
- stall_cnt  out  32  count of cycles with pc_stall=1, saturating

## Operation
- Decode fields: rd = [11:7], rs1 = [19:15], rs2 = [24:20], opcode = [6:0].
- EXE uses rs1 unless its opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
- EXE uses rs2 only for opcodes 0110011, 0100011 and 1100011.
- mem_op = mwb_dmem_sel∈{1,2}.
- dmem_req = mem_op (combinational, any state).
- wr_hit_k = mwb_reg_we && rd≠0 && rd == EXE rs_k && EXE uses rs_k.
- fwd_rs_k = wr_hit_k && mwb_dmem_sel≠1.
- load_use = mwb_dmem_sel==1 && (wr_hit_1 || wr_hit_2). Loads are not forwarded; the register file has no write-through, so the dependent instruction is held one cycle.
- FSM states: RUN and MEM_WAIT; counter wait_cnt of width clog2(TIMEOUT).
  - RUN, mem_op && !dmem_ready: freeze; next state MEM_WAIT, wait_cnt←0.
  - MEM_WAIT, dmem_ready: complete; next state RUN.
  - MEM_WAIT, !dmem_ready && wait_cnt==TIMEOUT-1: forced completion; mem_err←1, next state RUN.
  - MEM_WAIT, otherwise: freeze; wait_cnt increments.
- Per-cycle output priority:
  1. freeze: pc_stall = if2exe_stall = exe2mwb_stall = 1; flush = bubble = 0.
  2. else load_use (memory completion or no wait): pc_stall = if2exe_stall = 1, exe2mwb_bubble = 1, if2exe_flush = 0 (branch_taken ignored, since its operands are stale).
  3. else branch_taken: if2exe_flush = 1.
  4. else all controls 0.
- A branch taken during a freeze is applied in the cycle the freeze releases; EXE is held, so branch_taken persists.
- stall_cnt increments on every cycle with pc_stall=1 and saturates at 32'hFFFFFFFF.
- mem_err stays set until rst.

## Timing
- Reset values: state RUN, wait_cnt 0, mem_err 0, stall_cnt 0.
- While rst=1, all stall/flush/bubble/fwd outputs and dmem_req are forced 0.
- rst asserted mid-MEM_WAIT aborts the wait; the FSM is in RUN on the first cycle after rst deasserts.
- Control outputs are combinational from inputs and state, with zero latency to the pipeline-register enables.
- A single-cycle memory (dmem_ready together with dmem_req) adds 0 stall cycles.
- A memory ready N cycles after the request (N < TIMEOUT+1) adds N stall cycles.
- The longest wait is TIMEOUT+1 cycles with dmem_req high: 1 in RUN plus TIMEOUT in MEM_WAIT, the last of which advances the pipeline.
- load_use adds exactly 1 stall cycle. The next cycle has a bubble in MWB, so load_use cannot repeat for the same pair.
- Back-to-back memory ops: a new request is issued in the cycle after completion, with no idle cycle.

## Test plan
- ALU forwarding: MWB add x5 (rd=5, we=1, dmem_sel=0), EXE add x6,x5,x5 → fwd_rs1=fwd_rs2=1, no stall. With rd=0 → both 0.
- Memory wait: store in MWB, dmem_ready low 3 cycles then high → dmem_req high 4 cycles, pc_stall high 3 cycles, stall_cnt=3, mem_err=0.
- Load-use: load x7 in MWB with ready=1, EXE sub x8,x7,x1 → pc_stall=if2exe_stall=exe2mwb_bubble=1 for 1 cycle, fwd_rs1=0. Next cycle all 0.
- Branch during wait: branch_taken=1 while MWB load waits 2 cycles → if2exe_flush=0 during freeze, =1 in the release cycle.
- Timeout (TIMEOUT=4): dmem_ready held low → stalls for 4 cycles, release in 5th request cycle, mem_err=1 sticky; stall_cnt=4.
- Reset mid-wait: rst pulsed in MEM_WAIT → outputs 0 during rst; state RUN, stall_cnt=0, mem_err=0 afterward.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: the hazard controller (drives the pipeline controls).
// slave: the pipeline side (drives instructions and memory status).
interface pipe_hazard_ctrl_if;
  logic [31:0] exe_instr;
  logic [31:0] mwb_instr;
  logic        mwb_reg_we;
  logic [1:0]  mwb_dmem_sel;
  logic        dmem_ready;
  logic        branch_taken;

  logic        pc_stall;
  logic        if2exe_stall;
  logic        if2exe_flush;
  logic        exe2mwb_stall;
  logic        exe2mwb_bubble;
  logic        dmem_req;
  logic        fwd_rs1;
  logic        fwd_rs2;
  logic        mem_err;
  logic [31:0] stall_cnt;

  modport master (
    input  exe_instr, mwb_instr, mwb_reg_we, mwb_dmem_sel, dmem_ready, branch_taken,
    output pc_stall, if2exe_stall, if2exe_flush, exe2mwb_stall, exe2mwb_bubble,
           dmem_req, fwd_rs1, fwd_rs2, mem_err, stall_cnt
  );

  modport slave (
    output exe_instr, mwb_instr, mwb_reg_we, mwb_dmem_sel, dmem_ready, branch_taken,
    input  pc_stall, if2exe_stall, if2exe_flush, exe2mwb_stall, exe2mwb_bubble,
           dmem_req, fwd_rs1, fwd_rs2, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / memory-wait controller for the IF -> EXE -> MWB pipeline.
// Resolves data-memory waits (with timeout), load-use hazards and taken
// branches, drives EXE forwarding selects and counts stall cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  pipe_hazard_ctrl_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [31:0]      stall_cnt_q;

  logic [6:0] exe_op;
  logic [4:0] exe_rs1, exe_rs2, mwb_rd;
  logic       uses_rs1, uses_rs2;
  logic       wr_hit1, wr_hit2;
  logic       mem_op, is_load, load_use;
  logic       freeze;

  logic pc_stall, if2exe_stall, if2exe_flush, exe2mwb_stall, exe2mwb_bubble;
  logic dmem_req, fwd_rs1, fwd_rs2;

  // Instruction fields not needed for hazard detection.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.exe_instr[31:25], bus.exe_instr[14:7],
                               bus.mwb_instr[31:12], bus.mwb_instr[6:0]};

  // Operand-usage decode and MWB -> EXE dependency detection.
  always_comb begin
    exe_op   = bus.exe_instr[6:0];
    exe_rs1  = bus.exe_instr[19:15];
    exe_rs2  = bus.exe_instr[24:20];
    mwb_rd   = bus.mwb_instr[11:7];
    uses_rs1 = (exe_op != OP_LUI) && (exe_op != OP_AUIPC) && (exe_op != OP_JAL);
    uses_rs2 = (exe_op == OP_REG) || (exe_op == OP_STORE) || (exe_op == OP_BRANCH);
    wr_hit1  = bus.mwb_reg_we && (mwb_rd != 5'd0) && (mwb_rd == exe_rs1) && uses_rs1;
    wr_hit2  = bus.mwb_reg_we && (mwb_rd != 5'd0) && (mwb_rd == exe_rs2) && uses_rs2;
    is_load  = (bus.mwb_dmem_sel == 2'd1);
    mem_op   = (bus.mwb_dmem_sel == 2'd1) || (bus.mwb_dmem_sel == 2'd2);
    load_use = is_load && (wr_hit1 || wr_hit2);
  end

  // Wait FSM next state plus prioritised pipeline controls.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_err_d      = mem_err_q;
    freeze         = 1'b0;
    pc_stall       = 1'b0;
    if2exe_stall   = 1'b0;
    if2exe_flush   = 1'b0;
    exe2mwb_stall  = 1'b0;
    exe2mwb_bubble = 1'b0;
    dmem_req       = 1'b0;
    fwd_rs1        = 1'b0;
    fwd_rs2        = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_op && !bus.dmem_ready) begin
          freeze     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          mem_err_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (!rst) begin
      dmem_req = mem_op;
      fwd_rs1  = wr_hit1 && !is_load;
      fwd_rs2  = wr_hit2 && !is_load;
      if (freeze) begin
        pc_stall      = 1'b1;
        if2exe_stall  = 1'b1;
        exe2mwb_stall = 1'b1;
      end else if (load_use) begin
        // Stale operands: any branch decision this cycle is discarded.
        pc_stall       = 1'b1;
        if2exe_stall   = 1'b1;
        exe2mwb_bubble = 1'b1;
      end else if (bus.branch_taken) begin
        if2exe_flush = 1'b1;
      end
    end
  end

  // State, wait counter, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.pc_stall       = pc_stall;
  assign bus.if2exe_stall   = if2exe_stall;
  assign bus.if2exe_flush   = if2exe_flush;
  assign bus.exe2mwb_stall  = exe2mwb_stall;
  assign bus.exe2mwb_bubble = exe2mwb_bubble;
  assign bus.dmem_req       = dmem_req;
  assign bus.fwd_rs1        = fwd_rs1;
  assign bus.fwd_rs2        = fwd_rs2;
  assign bus.mem_err        = mem_err_q;
  assign bus.stall_cnt      = stall_cnt_q;

endmodule
